// File: rtl/prach_ditfft3_bf2.sv
// Radix-3 DIT butterfly for the PRACH FFT. It takes (a, s, d) sample triplets and emits X0, X1, X2
// on consecutive cycles. The rounding is half-up and the overall gain is 1/2.
module prach_ditfft3_bf2 #(
  parameter logic signed [17:0] COEF = 18'sd113512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [17:0] din_dr,
  input  logic signed [17:0] din_di,
  input  logic               din_dv,
  input  logic               sync_in,
  output logic signed [17:0] dout_dr,
  output logic signed [17:0] dout_di,
  output logic               dout_dv,
  output logic               sync_out
);

  localparam logic [1:0] PH_0 = 2'd0;
  localparam logic [1:0] PH_1 = 2'd1;
  localparam logic [1:0] PH_2 = 2'd2;

  localparam logic [1:0] EMIT_IDLE = 2'd0;
  localparam logic [1:0] EMIT_X1   = 2'd1;
  localparam logic [1:0] EMIT_X2   = 2'd2;

  localparam logic signed [37:0] ROUND_HALF = 38'sd131072;
  localparam logic signed [37:0] SAT_MAX    = 38'sd131071;
  localparam logic signed [37:0] SAT_MIN    = -38'sd131072;

  logic [1:0] phase;
  logic [1:0] emit_state;
  logic       cap_sync;
  logic       v0, v1, v2, v3;
  logic       s0, s1, s2, s3;

  logic signed [17:0] cap_a_re, cap_a_im, cap_s_re, cap_s_im;
  logic signed [17:0] trip_a_re, trip_a_im, trip_s_re, trip_s_im, trip_d_re, trip_d_im;

  logic signed [37:0] x0_acc_re, x0_acc_im, base_re, base_im;
  logic signed [35:0] tw_re, tw_im;

  logic signed [37:0] acc_x0_re, acc_x0_im, acc_x1_re, acc_x1_im, acc_x2_re, acc_x2_im;
  logic signed [17:0] r_x0_re, r_x0_im, r_x1_re, r_x1_im, r_x2_re, r_x2_im;
  logic signed [17:0] h_x1_re, h_x1_im, h_x2_re, h_x2_im;

  // Adds one half LSB, keeps bits [.. :18] (half-up rounding, gain 1/2), then clamps to 18 bits.
  function automatic logic signed [17:0] round_sat(input logic signed [37:0] acc);
    logic signed [37:0] q;
    q = (acc + ROUND_HALF) >>> 18;
    if (q > SAT_MAX)      round_sat = 18'sd131071;
    else if (q < SAT_MIN) round_sat = -18'sd131072;
    else                  round_sat = q[17:0];
  endfunction

  // Control path: phase tracking, valid/sync pipeline, output sequencing.
  // NOTE: every register is written with <= so that all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= PH_0;
      cap_sync   <= 1'b0;
      v0         <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      emit_state <= EMIT_IDLE;
      dout_dv    <= 1'b0;
      sync_out   <= 1'b0;
      dout_dr    <= '0;
      dout_di    <= '0;
    end else begin
      v0 <= 1'b0;
      if (din_dv) begin
        // A sync sample always opens a new triplet, which drops any partial one.
        if (sync_in) begin
          phase    <= PH_1;
          cap_sync <= 1'b1;
        end else begin
          case (phase)
            PH_0: begin
              phase    <= PH_1;
              cap_sync <= 1'b0;
            end
            PH_1:    phase <= PH_2;
            default: begin
              phase <= PH_0;
              v0    <= 1'b1;
            end
          endcase
        end
      end
      s0 <= cap_sync;
      v1 <= v0;
      s1 <= s0;
      v2 <= v1;
      s2 <= s1;
      v3 <= v2;
      s3 <= s2;

      dout_dv  <= 1'b0;
      sync_out <= 1'b0;
      if (v3) begin
        dout_dv    <= 1'b1;
        sync_out   <= s3;
        dout_dr    <= r_x0_re;
        dout_di    <= r_x0_im;
        emit_state <= EMIT_X1;
      end else begin
        case (emit_state)
          EMIT_X1: begin
            dout_dv    <= 1'b1;
            dout_dr    <= h_x1_re;
            dout_di    <= h_x1_im;
            emit_state <= EMIT_X2;
          end
          EMIT_X2: begin
            dout_dv    <= 1'b1;
            dout_dr    <= h_x2_re;
            dout_di    <= h_x2_im;
            emit_state <= EMIT_IDLE;
          end
          default: emit_state <= EMIT_IDLE;
        endcase
      end
    end
  end

  // Datapath: capture -> products -> sums -> round/saturate -> hold.
  // NOTE: these registers have no reset. The valid pipeline above qualifies them, so stale contents are never emitted.
  always_ff @(posedge clk) begin
    if (din_dv) begin
      if (sync_in || phase == PH_0) begin
        cap_a_re <= din_dr;
        cap_a_im <= din_di;
      end else if (phase == PH_1) begin
        cap_s_re <= din_dr;
        cap_s_im <= din_di;
      end else begin
        trip_a_re <= cap_a_re;
        trip_a_im <= cap_a_im;
        trip_s_re <= cap_s_re;
        trip_s_im <= cap_s_im;
        trip_d_re <= din_dr;
        trip_d_im <= din_di;
      end
    end

    if (v0) begin
      x0_acc_re <= (38'(trip_a_re) + 38'(trip_s_re)) <<< 17;
      x0_acc_im <= (38'(trip_a_im) + 38'(trip_s_im)) <<< 17;
      base_re   <= (38'(trip_a_re) <<< 17) - (38'(trip_s_re) <<< 16);
      base_im   <= (38'(trip_a_im) <<< 17) - (38'(trip_s_im) <<< 16);
      tw_re     <= 36'(COEF) * 36'(trip_d_im);
      tw_im     <= 36'(COEF) * 36'(trip_d_re);
    end

    if (v1) begin
      acc_x0_re <= x0_acc_re;
      acc_x0_im <= x0_acc_im;
      acc_x1_re <= base_re - 38'(tw_re);
      acc_x1_im <= base_im + 38'(tw_im);
      acc_x2_re <= base_re + 38'(tw_re);
      acc_x2_im <= base_im - 38'(tw_im);
    end

    if (v2) begin
      r_x0_re <= round_sat(acc_x0_re);
      r_x0_im <= round_sat(acc_x0_im);
      r_x1_re <= round_sat(acc_x1_re);
      r_x1_im <= round_sat(acc_x1_im);
      r_x2_re <= round_sat(acc_x2_re);
      r_x2_im <= round_sat(acc_x2_im);
    end

    // X1/X2 wait here while X0 is on the output. The next triplet cannot reach this stage for three cycles.
    if (v3) begin
      h_x1_re <= r_x1_re;
      h_x1_im <= r_x1_im;
      h_x2_re <= r_x2_re;
      h_x2_im <= r_x2_im;
    end
  end

endmodule

// File: tb/tb_prach_ditfft3_bf2.sv
// Bench for prach_ditfft3_bf2. It runs directed scenarios and then a randomized stream.
// Each run is scored against a triplet-level arithmetic model with per-cycle output timing.
module tb_prach_ditfft3_bf2;

  localparam longint C = 113512;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [17:0] din_dr = '0;
  logic signed [17:0] din_di = '0;
  logic               din_dv = 1'b0;
  logic               sync_in = 1'b0;
  logic signed [17:0] dout_dr, dout_di;
  logic               dout_dv, sync_out;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  prach_ditfft3_bf2 dut (
    .clk(clk), .rst(rst),
    .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv), .sync_in(sync_in),
    .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv), .sync_out(sync_out)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  typedef struct { int re; int im; bit sync; longint due; } exp_t;
  typedef struct { int re; int im; bit sync; } out_t;

  exp_t   exp_q[$];
  out_t   got_q[$];
  int     runs[$];
  int     run_len = 0;
  longint cyc = 0;
  bit     mon_en = 1'b0;
  int     last_re = 0, last_im = 0;

  int tr_re[3], tr_im[3];
  int cnt = 0;
  bit tsync = 1'b0;

  function automatic int round_half(input longint acc);
    longint q;
    q = (acc + 131072) >>> 18;
    if (q > 131071) return 131071;
    if (q < -131072) return -131072;
    return int'(q);
  endfunction

  // Reference model: gathers triplets by the input rules and schedules X0/X1/X2 at +4/+5/+6.
  always @(posedge clk) begin
    longint ar, ai, sr, si, dr, di;
    cyc++;
    if (rst) begin
      exp_q.delete();
      cnt = 0;
      last_re = 0;
      last_im = 0;
    end else if (din_dv) begin
      if (sync_in) begin
        cnt = 0;
        tsync = 1'b1;
      end else if (cnt == 0) begin
        tsync = 1'b0;
      end
      tr_re[cnt] = din_dr;
      tr_im[cnt] = din_di;
      cnt++;
      if (cnt == 3) begin
        ar = tr_re[0]; ai = tr_im[0];
        sr = tr_re[1]; si = tr_im[1];
        dr = tr_re[2]; di = tr_im[2];
        exp_q.push_back('{round_half((ar + sr) * 131072), round_half((ai + si) * 131072), tsync, cyc + 4});
        exp_q.push_back('{round_half(ar * 131072 - sr * 65536 - C * di),
                          round_half(ai * 131072 - si * 65536 + C * dr), 1'b0, cyc + 5});
        exp_q.push_back('{round_half(ar * 131072 - sr * 65536 + C * di),
                          round_half(ai * 131072 - si * 65536 - C * dr), 1'b0, cyc + 6});
        cnt = 0;
      end
    end
  end

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("missed_output_cycle", cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check("dout_dv", longint'(dout_dv), 1);
        check("dout_dr", longint'(dout_dr), e.re);
        check("dout_di", longint'(dout_di), e.im);
        check("sync_out", longint'(sync_out), longint'(e.sync));
        last_re = e.re;
        last_im = e.im;
      end else begin
        check("idle_dv", longint'(dout_dv), 0);
        check("idle_sync", longint'(sync_out), 0);
        check("hold_dr", longint'(dout_dr), last_re);
        check("hold_di", longint'(dout_di), last_im);
      end
      if (dout_dv) begin
        got_q.push_back('{int'(dout_dr), int'(dout_di), sync_out});
        run_len++;
      end else if (run_len > 0) begin
        runs.push_back(run_len);
        run_len = 0;
      end
    end
  end

  task automatic send(input int re, input int im, input bit s);
    din_dr  = 18'(re);
    din_di  = 18'(im);
    din_dv  = 1'b1;
    sync_in = s;
    @(posedge clk);
    #1;
    din_dv  = 1'b0;
    sync_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int rv();
    case ($urandom_range(0, 7))
      0:       return 131071;
      1:       return -131072;
      default: return int'($urandom_range(0, 262143)) - 131072;
    endcase
  endfunction

  task automatic directed(input string name, input int ar, input int ai, input int sr, input int si,
                          input int dr, input int di, input int e_re[3], input int e_im[3]);
    got_q.delete();
    send(ar, ai, 1'b1);
    send(sr, si, 1'b0);
    send(dr, di, 1'b0);
    idle(8);
    check({name, "_count"}, got_q.size(), 3);
    if (got_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("%s_X%0d_re", name, k), got_q[k].re, e_re[k]);
        check($sformatf("%s_X%0d_im", name, k), got_q[k].im, e_im[k]);
      end
      check({name, "_sync_x0"}, longint'(got_q[0].sync), 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    idle(2);
    check("rst_dv", longint'(dout_dv), 0);
    check("rst_dr", longint'(dout_dr), 0);
    check("rst_sync", longint'(sync_out), 0);
    rst = 1'b0;
    idle(1);

    directed("s1_basic", 100, 0, 0, 0, 0, 0, '{50, 50, 50}, '{0, 0, 0});
    directed("s2_sterm", 0, 0, 2000, 0, 0, 0, '{1000, -500, -500}, '{0, 0, 0});
    directed("s3_twiddle", 0, 0, 0, 0, 1000, 0, '{0, 0, 0}, '{0, 433, -433});
    directed("s4_sat", 131071, 0, -131072, 0, 0, -131072, '{0, 131071, 41548}, '{0, 0, 0});

    // Gapped triplet, then two back-to-back triplets.
    runs.delete();
    send(1234, -567, 1'b1); idle(2);
    send(-8000, 300, 1'b0); idle(2);
    send(4000, 9000, 1'b0);
    idle(3);
    send(rv(), rv(), 1'b0); send(rv(), rv(), 1'b0); send(rv(), rv(), 1'b0);
    send(rv(), rv(), 1'b0); send(rv(), rv(), 1'b0); send(rv(), rv(), 1'b0);
    idle(10);
    check("s5_runs", runs.size(), 2);
    if (runs.size() == 2) begin
      check("s5_gapped_run", runs[0], 3);
      check("s5_b2b_run", runs[1], 6);
    end

    // Sync on the second sample drops the partial triplet.
    got_q.delete();
    send(7, 7, 1'b1);
    send(500, -20, 1'b1);
    send(30, 40, 1'b0);
    send(-60, 90, 1'b0);
    idle(8);
    check("s6_sync_mid_count", got_q.size(), 3);

    // Reset lands on the X1 cycle, so only X0 escapes.
    got_q.delete();
    send(20000, 100, 1'b1);
    send(-300, 4000, 1'b0);
    send(700, -900, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("s6_rst_dv", longint'(dout_dv), 0);
    check("s6_rst_dr", longint'(dout_dr), 0);
    check("s6_rst_di", longint'(dout_di), 0);
    idle(8);
    check("s6_rst_count", got_q.size(), 1);

    // Randomized stream with gaps, occasional syncs and one mid-stream reset.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if (i == 150) begin
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
      end
      send(rv(), rv(), $urandom_range(0, 15) == 0);
    end
    idle(12);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
